noc_eject_port: RTL and testbench
=================================

# noc_eject_port

Receive side of a mesh node's local port. Accepts 11-bit flits from the router's local output over a valid/ready handshake and checks each destination field against the node ID. Accepted flits are buffered in a small FIFO and handed to the processor over a second valid/ready handshake. Drives the node's bit of `processor_ready_signals`, the complement of the configure-word injection path.

## Interface
- `NODE_ID`, 0: 2-bit node index in the 2x2 mesh.
- `DEPTH`, 4: FIFO entries, power of two, 2..16.
- `FLIT_W`, 11: flit width; fixed by the shared package.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_flit`  in  11  flit from router local output.
- `rx_valid`  in  1  `rx_flit` valid.
- `rx_ready`  out  1  port can take a flit this cycle.
- `pe_data`  out  7  payload to processor.
- `pe_src`  out  2  source node of head flit.
- `pe_valid`  out  1  head flit available.
- `pe_ready`  in  1  processor consumes head flit.
- `processor_ready`  out  1  node idle: FIFO empty and FSM in IDLE.
- `misroute`  out  1  one-cycle pulse, flit dropped for wrong destination.

## Operation
- Flit format: [1:0] dest, [3:2] src, [10:4] payload.
- Transfers occur only when valid and ready are both high at a rising edge. Either side's valid is held until its transfer.
- FSM states:
  - IDLE: FIFO empty. A transfer moves to ACTIVE.
  - ACTIVE: FIFO non-empty and not full. Filling the last entry moves to FULL. The last entry popped with no push moves to IDLE.
  - FULL: `rx_ready`=0. Any pop moves to ACTIVE.
- Accept rule:
  - A transferred flit is pushed only if dest == `NODE_ID`.
  - Otherwise it is dropped and `misroute` pulses on the following cycle.
  - `rx_ready` is still 1 for misrouted flits, so the router never stalls on them.
- Simultaneous push and pop in FULL: not possible, since `rx_ready`=0.
- Simultaneous push and pop in ACTIVE: count is unchanged, state is unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- `pe_data`/`pe_src` reflect the FIFO head. They are don't-care while `pe_valid`=0.
- Reset mid-transfer: all buffered flits are discarded. No partial state survives.

## Timing
- Reset values:
  - `rx_ready`=1
  - `pe_valid`=0
  - `pe_data`=0
  - `pe_src`=0
  - `processor_ready`=1
  - `misroute`=0
  - FSM=IDLE
  - pointers and count=0
- `rx_ready` is registered: it equals (count < DEPTH) as of the previous edge.
- Latency from accepted flit to `pe_valid`=1 is one cycle; there is no bypass.
- `pe_valid` drops the cycle after a pop that empties the FIFO.
- `processor_ready` falls in the cycle after the first accept and rises in the cycle after the FIFO drains.
- Throughput: one flit per cycle in each direction.

## Configuration
- `NOC_EJECT_ERRCNT_EN` defined:
  - Adds output `err_count` [7:0], incremented on each misrouted flit and saturating at 255.
  - `err_count` resets to 0.
- Undefined: no port, no counter. `misroute` pulse is still present.

## Structure
- Shared package holds:
  - the flit field offsets and widths (`DEST_LSB`, `SRC_LSB`, `PAY_LSB`, `FLIT_W`=11);
  - the node ID constants 0..3;
  - the FSM state encoding (IDLE/ACTIVE/FULL, 2 bits).
- One sub-module: `noc_sync_fifo`, parameterised DEPTH x FLIT_W, with push/pop/full/empty/count outputs.

## Test plan
- After reset, with no traffic: `rx_ready`=1, `pe_valid`=0, `processor_ready`=1.
- NODE_ID=1. Send flit 11'b0000100_00_01 with `pe_ready`=0.
  - Next cycle: `pe_valid`=1, `pe_data`=7'h04, `pe_src`=0, `processor_ready`=0.
- Send dest=2 to NODE_ID=1.
  - `misroute` pulses for 1 cycle, `pe_valid` stays 0.
  - `err_count`=1 when the macro is enabled.
- DEPTH=4 with `pe_ready`=0: push 4 valid flits.
  - `rx_ready`=0 and the 5th flit is held.
  - Raise `pe_ready` for 1 cycle: `rx_ready` returns to 1 and the 5th flit is accepted.
  - Drain all five: payloads come out in order.
- Continuous push and pop at 1 flit/cycle for 20 flits: count stays 1, no stall, order preserved.
- Assert `reset` low with 3 flits buffered: `pe_valid`=0 immediately (asynchronously), `processor_ready`=1, count=0 after release.

Source files
------------

// File: rtl/noc_eject_port_pkg.sv
// Shared flit layout, node IDs and eject-port FSM encoding for the 2x2 mesh.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_eject_port_pkg;

    // Flit layout: [1:0] dest, [3:2] src, [10:4] payload
    localparam int FLIT_W   = 11;
    localparam int DEST_LSB = 0;
    localparam int DEST_W   = 2;
    localparam int SRC_LSB  = 2;
    localparam int SRC_W    = 2;
    localparam int PAY_LSB  = 4;
    localparam int PAY_W    = 7;

    localparam logic [1:0] NODE_0 = 2'd0;
    localparam logic [1:0] NODE_1 = 2'd1;
    localparam logic [1:0] NODE_2 = 2'd2;
    localparam logic [1:0] NODE_3 = 2'd3;

    typedef struct packed {
        logic [PAY_W-1:0]  payload;
        logic [SRC_W-1:0]  src;
        logic [DEST_W-1:0] dest;
    } flit_t;

    // What the FIFO keeps per entry; dest is dropped once it has been checked.
    typedef struct packed {
        logic [PAY_W-1:0] payload;
        logic [SRC_W-1:0] src;
    } pe_ent_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } eject_state_e;

    function automatic pe_ent_t flit_to_ent(input flit_t f);
        pe_ent_t e;
        e.payload = f.payload;
        e.src     = f.src;
        return e;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Generic synchronous FIFO, DEPTH x WIDTH, DEPTH a power of two.
// Latency: a pushed entry is visible at pop_dat/!empty the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
//
// Ports: clock, reset (async active-low), push/push_dat, pop/pop_dat,
//        full, empty, count (log2(DEPTH)+1 bits).
module noc_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr];
    assign count   = cnt;

    // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: contents are only observable through count.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/noc_eject_port.sv
// Mesh node local eject port: filters flits by destination, buffers them, hands them to the PE.
// Latency: accepted flit shows on pe_valid one cycle later (no bypass); misroute pulses one cycle later.
// Backpressure: rx_ready (registered) drops only when the FIFO is full; misrouted flits never stall.
//
// Ports: clock, reset (async active-low); rx_flit/rx_valid/rx_ready from router;
//        pe_data/pe_src/pe_valid/pe_ready to processor; processor_ready (idle);
//        misroute pulse; err_count[7:0] only when NOC_EJECT_ERRCNT_EN is defined.
// Flit width comes from noc_eject_port_pkg::FLIT_W.
module noc_eject_port
    import noc_eject_port_pkg::*;
#(
    parameter int NODE_ID = 0,
    parameter int DEPTH   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [FLIT_W-1:0] rx_flit,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [PAY_W-1:0]  pe_data,
    output logic [SRC_W-1:0]  pe_src,
    output logic              pe_valid,
    input  logic              pe_ready,
    output logic              processor_ready,
    output logic              misroute
`ifdef NOC_EJECT_ERRCNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [DEST_W-1:0] MY_ID    = DEST_W'(NODE_ID);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);

    flit_t        rx_f;
    pe_ent_t      head;
    logic         rx_xfer;
    logic         dest_hit;
    logic         push;
    logic         drop;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [CW-1:0] fifo_count;
    logic         rx_ready_q;
    logic         rx_ready_d;
    logic         misroute_q;
    eject_state_e state_q;
    eject_state_e state_d;

    assign rx_f     = flit_t'(rx_flit);
    assign rx_xfer  = rx_valid && rx_ready_q;
    assign dest_hit = (rx_f.dest == MY_ID);
    assign push     = rx_xfer && dest_hit && !fifo_full;
    assign drop     = rx_xfer && !dest_hit;
    assign pop      = pe_valid && pe_ready;

    noc_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(pe_ent_t))
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (flit_to_ent(rx_f)),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // pe_valid follows the registered count, so reset clears it immediately.
    // Head fields are forced to zero while empty so stale storage never leaks out.
    assign pe_valid = !fifo_empty;
    assign pe_data  = pe_valid ? head.payload : '0;
    assign pe_src   = pe_valid ? head.src     : '0;
    assign rx_ready = rx_ready_q;
    assign misroute = misroute_q;

    // FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state. Only pushes (not dropped flits) leave IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (push) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (push && !pop && (fifo_count == CNT_LAST))
                    state_d = ST_FULL;
                else if (pop && !push && (fifo_count == CNT_ONE))
                    state_d = ST_IDLE;
            end
            ST_FULL: begin
                if (pop) state_d = ST_ACTIVE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. rx_ready is registered from the next state, which makes it
    // equal to (count < DEPTH) after each edge.
    always_comb begin
        processor_ready = (state_q == ST_IDLE) && fifo_empty;
        rx_ready_d      = (state_d != ST_FULL);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_ready_q <= 1'b1;
            misroute_q <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready_d;
            misroute_q <= drop;
        end
    end

`ifdef NOC_EJECT_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                          err_cnt_q <= '0;
        else if (drop && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_noc_eject_port.sv
// Self-checking bench for noc_eject_port (NODE_ID=1, DEPTH=4), queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_noc_eject_port;

    localparam int NODE_ID = 1;
    localparam int DEPTH   = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [10:0] rx_flit;
    logic        rx_valid;
    logic        rx_ready;
    logic [6:0]  pe_data;
    logic [1:0]  pe_src;
    logic        pe_valid;
    logic        pe_ready;
    logic        processor_ready;
    logic        misroute;
`ifdef NOC_EJECT_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    noc_eject_port #(
        .NODE_ID (NODE_ID),
        .DEPTH   (DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .rx_flit         (rx_flit),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .pe_data         (pe_data),
        .pe_src          (pe_src),
        .pe_valid        (pe_valid),
        .pe_ready        (pe_ready),
        .processor_ready (processor_ready),
        .misroute        (misroute)
`ifdef NOC_EJECT_ERRCNT_EN
        ,
        .err_count       (err_count)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: queue of {payload, src} the processor should see, in order.
    logic [8:0] mq[$];
    logic       exp_mis;
    int         exp_err;
    logic       last_acc;
    int         n_tests;
    int         n_fail;

    function automatic logic [10:0] mk(input logic [1:0] d, input logic [1:0] s, input logic [6:0] p);
        return {p, s, d};
    endfunction

    // Advance one clock; decide transfers from the model's own view of occupancy.
    task automatic step();
        logic        acc;
        logic        pp;
        logic [10:0] f;
        acc = rx_valid && (mq.size() < DEPTH);
        pp  = pe_ready && (mq.size() > 0);
        f   = rx_flit;
        @(posedge clock);
        #1;
        if (pp) void'(mq.pop_front());
        exp_mis = 1'b0;
        if (acc) begin
            if (f[1:0] == 2'(NODE_ID)) mq.push_back(f[10:2]);
            else begin
                exp_mis = 1'b1;
                if (exp_err < 255) exp_err++;
            end
        end
        last_acc = acc;
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_valid = 1'b0; rx_flit = '0; pe_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        mq.delete(); exp_err = 0; exp_mis = 1'b0; last_acc = 1'b0;
        #2;
        n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        n_tests++; if (pe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pe_valid: got %b want 0", pe_valid); end
        n_tests++; if (processor_ready !== 1'b1) begin n_fail++; $display("FAIL reset_proc_ready: got %b want 1", processor_ready); end
        n_tests++; if (misroute !== 1'b0) begin n_fail++; $display("FAIL reset_misroute: got %b want 0", misroute); end
        n_tests++; if ({pe_data, pe_src} !== 9'd0) begin n_fail++; $display("FAIL reset_pe_fields: got %h want 0", {pe_data, pe_src}); end
`ifdef NOC_EJECT_ERRCNT_EN
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
`endif
    endtask

    task automatic test_single();
        rx_flit = 11'b0000100_00_01; rx_valid = 1'b1; pe_ready = 1'b0;
        step();
        rx_valid = 1'b0;
        n_tests++; if (pe_valid !== 1'b1) begin n_fail++; $display("FAIL single_pe_valid: got %b want 1", pe_valid); end
        n_tests++; if (pe_data !== 7'h04) begin n_fail++; $display("FAIL single_pe_data: got %h want 04", pe_data); end
        n_tests++; if (pe_src !== 2'd0) begin n_fail++; $display("FAIL single_pe_src: got %0d want 0", pe_src); end
        n_tests++; if (processor_ready !== 1'b0) begin n_fail++; $display("FAIL single_proc_ready: got %b want 0", processor_ready); end
        pe_ready = 1'b1;
        step();
        pe_ready = 1'b0;
        n_tests++; if (pe_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid: got %b want 0", pe_valid); end
        n_tests++; if (processor_ready !== 1'b1) begin n_fail++; $display("FAIL single_drain_proc_ready: got %b want 1", processor_ready); end
    endtask

    task automatic test_misroute();
        rx_flit = mk(2'd2, 2'd3, 7'($urandom)); rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        n_tests++; if (misroute !== 1'b1) begin n_fail++; $display("FAIL misroute_pulse: got %b want 1", misroute); end
        n_tests++; if (pe_valid !== 1'b0) begin n_fail++; $display("FAIL misroute_pe_valid: got %b want 0", pe_valid); end
        n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL misroute_rx_ready: got %b want 1", rx_ready); end
`ifdef NOC_EJECT_ERRCNT_EN
        n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL misroute_err_count: got %0d want 1", err_count); end
`endif
        step();
        n_tests++; if (misroute !== 1'b0) begin n_fail++; $display("FAIL misroute_one_cycle: got %b want 0", misroute); end
    endtask

    task automatic test_full();
        logic [6:0] pay [5];
        for (int i = 0; i < 5; i++) pay[i] = 7'($urandom);
        pe_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_flit = mk(2'd1, 2'(i), pay[i]); rx_valid = 1'b1;
            step();
        end
        n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL full_rx_ready: got %b want 0", rx_ready); end
        rx_flit = mk(2'd1, 2'd2, pay[4]);
        step();
        n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL full_held_rx_ready: got %b want 0", rx_ready); end
        n_tests++; if (pe_data !== pay[0]) begin n_fail++; $display("FAIL full_head0: got %h want %h", pe_data, pay[0]); end
        pe_ready = 1'b1;
        step();
        pe_ready = 1'b0;
        n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL full_rx_ready_back: got %b want 1", rx_ready); end
        step();
        rx_valid = 1'b0;
        n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL full_fifth_taken: got %b want 0", rx_ready); end
        pe_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            n_tests++; if (pe_valid !== 1'b1 || pe_data !== pay[i]) begin n_fail++; $display("FAIL full_drain_%0d: got v=%b d=%h want v=1 d=%h", i, pe_valid, pe_data, pay[i]); end
            step();
        end
        pe_ready = 1'b0;
        n_tests++; if (pe_valid !== 1'b0 || processor_ready !== 1'b1) begin n_fail++; $display("FAIL full_drained: got v=%b pr=%b want v=0 pr=1", pe_valid, processor_ready); end
    endtask

    task automatic test_stream();
        rx_flit = mk(2'd1, 2'($urandom), 7'($urandom)); rx_valid = 1'b1; pe_ready = 1'b0;
        step();
        pe_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            n_tests++; if (pe_valid !== 1'b1 || rx_ready !== 1'b1 || processor_ready !== 1'b0) begin n_fail++; $display("FAIL stream_flags_%0d: got v=%b r=%b pr=%b want 1 1 0", i, pe_valid, rx_ready, processor_ready); end
            n_tests++; if ({pe_data, pe_src} !== mq[0]) begin n_fail++; $display("FAIL stream_order_%0d: got %h want %h", i, {pe_data, pe_src}, mq[0]); end
            rx_flit = mk(2'd1, 2'($urandom), 7'($urandom));
            step();
        end
        rx_valid = 1'b0;
        step();
        pe_ready = 1'b0;
        n_tests++; if (pe_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid: got %b want 0", pe_valid); end
    endtask

    task automatic test_reset_mid();
        pe_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_flit = mk(2'd1, 2'd1, 7'($urandom)); rx_valid = 1'b1;
            step();
        end
        rx_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_tests++; if (pe_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_pe_valid: got %b want 0", pe_valid); end
        n_tests++; if (processor_ready !== 1'b1 || rx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got pr=%b r=%b want 1 1", processor_ready, rx_ready); end
        mq.delete(); exp_err = 0; exp_mis = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        step();
        n_tests++; if (pe_valid !== 1'b0 || processor_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_after: got v=%b pr=%b want 0 1", pe_valid, processor_ready); end
        rx_flit = mk(2'd1, 2'd3, 7'h5A); rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        n_tests++; if ({pe_valid, pe_data, pe_src} !== {1'b1, 7'h5A, 2'd3}) begin n_fail++; $display("FAIL rstmid_fresh: got %h want %h", {pe_valid, pe_data, pe_src}, {1'b1, 7'h5A, 2'd3}); end
        pe_ready = 1'b1;
        step();
        pe_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] d;
        for (int c = 0; c < 400; c++) begin
            if (!rx_valid || last_acc) begin
                rx_valid = ($urandom_range(0, 3) != 0);
                d = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'd1;
                rx_flit = mk(d, 2'($urandom), 7'($urandom));
            end
            pe_ready = ($urandom_range(0, 2) != 0);
            step();
            n_tests++; if (rx_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rand_rx_ready_%0d: got %b want %b", c, rx_ready, mq.size() < DEPTH); end
            n_tests++; if (pe_valid !== (mq.size() > 0) || processor_ready !== (mq.size() == 0)) begin n_fail++; $display("FAIL rand_flags_%0d: got v=%b pr=%b occupancy %0d", c, pe_valid, processor_ready, mq.size()); end
            n_tests++; if (misroute !== exp_mis) begin n_fail++; $display("FAIL rand_misroute_%0d: got %b want %b", c, misroute, exp_mis); end
            if (mq.size() > 0) begin
                n_tests++; if ({pe_data, pe_src} !== mq[0]) begin n_fail++; $display("FAIL rand_head_%0d: got %h want %h", c, {pe_data, pe_src}, mq[0]); end
            end
`ifdef NOC_EJECT_ERRCNT_EN
            n_tests++; if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL rand_err_count_%0d: got %0d want %0d", c, err_count, exp_err); end
`endif
        end
        rx_valid = 1'b0; pe_ready = 1'b1;
        repeat (DEPTH + 1) step();
        pe_ready = 1'b0;
        n_tests++; if (processor_ready !== 1'b1) begin n_fail++; $display("FAIL rand_final_idle: got %b want 1", processor_ready); end
`ifdef NOC_EJECT_ERRCNT_EN
        rx_flit = mk(2'd0, 2'd0, 7'd0); rx_valid = 1'b1;
        repeat (260) step();
        rx_valid = 1'b0;
        n_tests++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL err_saturate: got %0d want 255", err_count); end
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single();
        test_misroute();
        test_full();
        test_stream();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
